receptor_uart: RTL and testbench

RECEPTOR_UART -- requirements
Module: receptor_uart

---
 rtl/receptor_uart_pkg.sv | 28 ++
 rtl/receptor_uart_if.sv | 28 ++
 rtl/receptor_uart_generador_ticks.sv | 33 +++
 rtl/receptor_uart.sv | 149 ++++++++++++++
 tb/tb_receptor_uart.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/receptor_uart_pkg.sv
// receptor_uart shared package: FSM state encoding, oversampling and
// frame constants, and the baud divider helper.
package receptor_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_W     = 8;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        START_BIT   = 3'd1,
        DATOS       = 3'd2,
        STOP_BIT    = 3'd3,
        ESPERA_IDLE = 3'd4
    } estado_t;

    // Rounded clocks-per-sample-tick, never below 1.
    function automatic int calc_div(input int clk_freq,
                                    input int baud,
                                    input int os);
        int den;
        int q;
        den = baud * os;
        q   = (clk_freq + den / 2) / den;
        return (q < 1) ? 1 : q;
    endfunction

endpackage

// File: rtl/receptor_uart_if.sv
// receptor_uart bus: serial line in, received byte and status pulses out.
// master = receiver side, slave = line driver / byte consumer side.
interface receptor_uart_if;
    import receptor_pkg::*;

    logic              rx;
    logic [DATA_W-1:0] data;
    logic              dato_listo;
    logic              error_trama;
    logic              ocupado;

    modport master (
        input  rx,
        output data,
        output dato_listo,
        output error_trama,
        output ocupado
    );

    modport slave (
        output rx,
        input  data,
        input  dato_listo,
        input  error_trama,
        input  ocupado
    );

endinterface

// File: rtl/receptor_uart_generador_ticks.sv
// generador_ticks: free-running sample tick, one clk pulse every DIV clocks.
// Ports: clk, reset (async, active low), tick (out).
module generador_ticks
    import receptor_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With DIV = 1 the compare is always true: tick every clock.
    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/receptor_uart.sv
// receptor_uart: 8N1 UART receiver with 16x oversampling, mid-bit sampling,
// glitch rejection and framing-error detection.
// Ports: clk, reset (async, active low), bus (master: rx in;
// data, dato_listo, error_trama, ocupado out).
module receptor_uart
    import receptor_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic           clk,
    input  logic           reset,
    receptor_uart_if.master bus
);

    localparam logic [3:0] MID  = 4'(MID_SAMPLE);
    localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] IDX7 = 3'(DATA_W - 1);

    logic tick;

    generador_ticks #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_ticks (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    logic              rx_s1_q, rx_s1_d;
    logic              rx_s2_q, rx_s2_d;
    estado_t           state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              listo_q, listo_d;
    logic              err_q, err_d;

    logic rx_s;
    assign rx_s = rx_s2_q;

    always_comb begin
        rx_s1_d = bus.rx;
        rx_s2_d = rx_s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        listo_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick && !rx_s) begin
                    state_d = START_BIT;
                    cnt_d   = '0;
                end
            end
            START_BIT: begin
                if (tick) begin
                    if (cnt_q == MID) begin
                        // Still low at mid start bit: real frame.
                        if (!rx_s) begin
                            state_d = DATOS;
                            cnt_d   = '0;
                            idx_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            DATOS: begin
                // Counter restarts at mid start bit, so count 15
                // lands at the middle of each data bit.
                if (tick) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[DATA_W-1:1]};
                        if (idx_q == IDX7) state_d = STOP_BIT;
                        else               idx_d = idx_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            STOP_BIT: begin
                if (tick) begin
                    if (cnt_q == LAST) begin
                        if (rx_s) begin
                            data_d  = shift_q;
                            listo_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ESPERA_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ESPERA_IDLE: begin
                if (rx_s) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            listo_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rx_s1_q <= rx_s1_d;
            rx_s2_q <= rx_s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            listo_q <= listo_d;
            err_q   <= err_d;
        end
    end

    assign bus.data        = data_q;
    assign bus.dato_listo  = listo_q;
    assign bus.error_trama = err_q;
    assign bus.ocupado     = (state_q != IDLE);

endmodule

// File: tb/tb_receptor_uart.sv
// Directed plus randomized bench for receptor_uart at 16 clk per bit.
// A frame-level model (queue of sent bytes) predicts every result.
module tb_receptor_uart;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    receptor_uart_if u_if();

    receptor_uart #(
        .CLK_FREQ  (1843200),
        .BAUD      (115200),
        .OVERSAMPLE(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (u_if.master)
    );

    int total = 0;
    int bad   = 0;

    int         cyc        = 0;
    logic [7:0] q_data[$];
    int         q_cyc[$];
    logic       q_ocup[$];
    int         err_cnt    = 0;
    int         both_cnt   = 0;
    int         bad_change = 0;
    logic [7:0] prev_data  = 8'h00;
    logic       busy_seen  = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            prev_data = u_if.data;
        end else begin
            if (u_if.dato_listo) begin
                q_data.push_back(u_if.data);
                q_cyc.push_back(cyc);
                q_ocup.push_back(u_if.ocupado);
            end
            if (u_if.error_trama) err_cnt++;
            if (u_if.dato_listo && u_if.error_trama) both_cnt++;
            if (u_if.data !== prev_data && !u_if.dato_listo) bad_change++;
            prev_data = u_if.data;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame bits LSB first: start, 8 data bits, stop.
    function automatic logic [9:0] frame(input logic [7:0] b,
                                         input logic stop);
        return {stop, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [9:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            u_if.rx = fr[i];
            repeat (16) @(negedge clk);
            if (i == 2) busy_seen = u_if.ocupado;
        end
    endtask

    logic [7:0] exp_q[$];
    int         e0;

    initial begin
        reset   = 1'b0;
        u_if.rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data",  32'(u_if.data), 32'h00);
        chk("rst_listo", 32'(u_if.dato_listo), 32'd0);
        chk("rst_err",   32'(u_if.error_trama), 32'd0);
        chk("rst_busy",  32'(u_if.ocupado), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame 0x55
        busy_seen = 1'b0;
        send_bits(frame(8'h55, 1'b1), 10);
        repeat (4) @(negedge clk);
        chk("f55_cnt", 32'(q_data.size()), 32'd1);
        if (q_data.size() == 1) begin
            chk("f55_data", 32'(q_data[0]), 32'h55);
            chk("f55_busy_at_pulse", 32'(q_ocup[0]), 32'd0);
        end
        chk("f55_busy_mid", 32'(busy_seen), 32'd1);
        chk("f55_err", 32'(err_cnt), 32'd0);
        chk("f55_idle", 32'(u_if.ocupado), 32'd0);
        q_data.delete(); q_cyc.delete(); q_ocup.delete();

        // Back-to-back 0xA3, 0x0F
        send_bits(frame(8'hA3, 1'b1), 10);
        send_bits(frame(8'h0F, 1'b1), 10);
        repeat (4) @(negedge clk);
        chk("b2b_cnt", 32'(q_data.size()), 32'd2);
        if (q_data.size() == 2) begin
            chk("b2b_d0", 32'(q_data[0]), 32'hA3);
            chk("b2b_d1", 32'(q_data[1]), 32'h0F);
            chk("b2b_gap", 32'(q_cyc[1] - q_cyc[0]), 32'd160);
        end
        chk("b2b_hold", 32'(u_if.data), 32'h0F);
        q_data.delete(); q_cyc.delete(); q_ocup.delete();

        // Glitch: 4 clk low
        u_if.rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("gl_busy", 32'(u_if.ocupado), 32'd1);
        u_if.rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("gl_idle", 32'(u_if.ocupado), 32'd0);
        chk("gl_nopulse", 32'(q_data.size()), 32'd0);
        chk("gl_data", 32'(u_if.data), 32'h0F);
        chk("gl_err", 32'(err_cnt), 32'd0);

        // Framing error 0xC6, line held low afterwards
        e0 = err_cnt;
        send_bits(frame(8'hC6, 1'b0), 10);
        repeat (40) @(negedge clk);
        chk("fe_err", 32'(err_cnt - e0), 32'd1);
        chk("fe_nolisto", 32'(q_data.size()), 32'd0);
        chk("fe_data", 32'(u_if.data), 32'h0F);
        chk("fe_busy", 32'(u_if.ocupado), 32'd1);
        u_if.rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("fe_idle", 32'(u_if.ocupado), 32'd0);
        chk("fe_err_once", 32'(err_cnt - e0), 32'd1);

        // Reset during bit 4 of 0x81 (bit 4 is 0)
        send_bits(frame(8'h81, 1'b1), 5);
        u_if.rx = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ra_data",  32'(u_if.data), 32'h00);
        chk("ra_busy",  32'(u_if.ocupado), 32'd0);
        chk("ra_listo", 32'(u_if.dato_listo), 32'd0);
        chk("ra_err",   32'(u_if.error_trama), 32'd0);
        u_if.rx = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("ra_nopulse", 32'(q_data.size()), 32'd0);
        send_bits(frame(8'h81, 1'b1), 10);
        repeat (4) @(negedge clk);
        chk("ra_cnt", 32'(q_data.size()), 32'd1);
        if (q_data.size() == 1) chk("ra_d", 32'(q_data[0]), 32'h81);
        q_data.delete(); q_cyc.delete(); q_ocup.delete();

        // Random bytes with random idle gaps (including none)
        for (int k = 0; k < 6; k++) begin
            logic [7:0] b;
            int         gap;
            b   = 8'($urandom_range(0, 255));
            gap = int'($urandom_range(0, 20));
            exp_q.push_back(b);
            send_bits(frame(b, 1'b1), 10);
            u_if.rx = 1'b1;
            repeat (gap) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("rnd_cnt", 32'(q_data.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < q_data.size())
                chk($sformatf("rnd_d%0d", k), 32'(q_data[k]), 32'(exp_q[k]));
        end

        chk("never_both", 32'(both_cnt), 32'd0);
        chk("data_only_on_listo", 32'(bad_change), 32'd0);
        chk("err_total", 32'(err_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
